mmio_input_ctrl: RTL

Parametrised memory-mapped input controller that replaces the fixed ad-hoc switch/key sampling at the processor top level. It synchronises and debounces `NCH` raw input channels, exposes the debounced levels, and captures rising and/or falling edges in sticky write-1-to-clear flags. It sits on the data-memory I/O decode next to the HEX/LEDR/LEDG registers and returns read data combinationally, so the single-cycle datapath can load it like any other memory word.

---
 rtl/mmio_input_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mmio_input_ctrl.sv
// mmio_input_ctrl: memory-mapped input controller for switches/keys.
// Each channel is optionally inverted, passed through a 2-flop synchroniser and a
// debouncer. The debounced levels are readable as DATA. Debounced edges are captured
// in sticky write-1-to-clear EDGE flags.
// Optional feature macro: MMIO_INPUT_IRQ_EN adds the IMASK register and the irq output.
//
// Register map (byte offsets from BASE_ADDR):
//   +0x0 DATA  RO    debounced levels
//   +0x4 EDGE  RW1C  sticky edge flags
//   +0x8 CTRL  RW    [1:0] edge mode (01 rise, 10 fall, 11 both), [2] invert
//   +0xC IMASK RW    per-channel irq enable (reads 0 without MMIO_INPUT_IRQ_EN)
module mmio_input_ctrl #(
    parameter int               NCH             = 10,
    parameter int               DEBOUNCE_CYCLES = 50,
    parameter int               CNT_BITS        = 16,
    parameter int               DBITS           = 32,
    parameter logic [DBITS-1:0] BASE_ADDR       = 32'hF0000014
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   in_raw,
    input  logic [DBITS-1:0] addr,
    input  logic             wr_en,
    input  logic [DBITS-1:0] wr_data,
    output logic [DBITS-1:0] rd_data
`ifdef MMIO_INPUT_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam logic [DBITS-1:0]    ADDR_DATA  = BASE_ADDR;
    localparam logic [DBITS-1:0]    ADDR_EDGE  = BASE_ADDR + DBITS'(4);
    localparam logic [DBITS-1:0]    ADDR_CTRL  = BASE_ADDR + DBITS'(8);
    localparam logic [DBITS-1:0]    ADDR_IMASK = BASE_ADDR + DBITS'(12);
    localparam logic [CNT_BITS-1:0] CNT_MAX    = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    logic [NCH-1:0]      sync1_q, sync1_d;
    logic [NCH-1:0]      sync2_q, sync2_d;
    logic [NCH-1:0]      deb_q, deb_d;
    logic [NCH-1:0]      edge_q, edge_d;
    logic [CNT_BITS-1:0] cnt_q [NCH];
    logic [CNT_BITS-1:0] cnt_d [NCH];
    logic [2:0]          ctrl_q, ctrl_d;
    logic [NCH-1:0]      set_edge;
    logic [NCH-1:0]      clr_edge;
    logic                wr_edge, wr_ctrl;

    // wr_data bits above the register widths are intentionally ignored
    logic unused_wr_data;
    assign unused_wr_data = ^wr_data;

    assign wr_edge = wr_en && (addr == ADDR_EDGE);
    assign wr_ctrl = wr_en && (addr == ADDR_CTRL);

    // Inversion is applied before the synchroniser so toggling it debounces like an input change
    always_comb begin
        sync1_d = in_raw ^ {NCH{ctrl_q[2]}};
        sync2_d = sync1_q;
    end

    // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        deb_d    = deb_q;
        set_edge = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i]    = sync2_q[i];
                    set_edge[i] = sync2_q[i] ? ctrl_q[0] : ctrl_q[1];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_BITS'(1);
                end
            end
        end
    end

    // Register writes; a capture on the same edge as a W1C clear keeps the flag set
    always_comb begin
        clr_edge = wr_edge ? wr_data[NCH-1:0] : '0;
        edge_d   = (edge_q & ~clr_edge) | set_edge;
        ctrl_d   = wr_ctrl ? wr_data[2:0] : ctrl_q;
    end

`ifdef MMIO_INPUT_IRQ_EN
    logic [NCH-1:0] imask_q, imask_d;

    // Interrupt mask register
    always_comb begin
        imask_d = (wr_en && (addr == ADDR_IMASK)) ? wr_data[NCH-1:0] : imask_q;
    end

    // Interrupt mask flop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) imask_q <= '0;
        else        imask_q <= imask_d;
    end

    assign irq = |(edge_q & imask_q);
`endif

    // Combinational read mux; unmapped or misaligned addresses read 0
    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_DATA:  rd_data[NCH-1:0] = deb_q;
            ADDR_EDGE:  rd_data[NCH-1:0] = edge_q;
            ADDR_CTRL:  rd_data[2:0]     = ctrl_q;
`ifdef MMIO_INPUT_IRQ_EN
            ADDR_IMASK: rd_data[NCH-1:0] = imask_q;
`else
            ADDR_IMASK: rd_data          = '0;
`endif
            default:    rd_data          = '0;
        endcase
    end

    // State flops; reset abandons any debounce in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            edge_q  <= '0;
            ctrl_q  <= '0;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            edge_q  <= edge_d;
            ctrl_q  <= ctrl_d;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

endmodule
